// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter slice.
//   DEF_WIDTH   : default count register width
//   DEF_MODULUS : default count modulus (count range 0..MODULUS-1)
//   dir_e       : direction encoding on the dir port (DIR_UP=1, DIR_DOWN=0)
package counter_pkg;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_MODULUS = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : counter_pkg

// File: rtl/count_next.sv
// Next-count computation for the modulo up/down counter.
//   ucount  : current count
//   dir     : 1 = up, 0 = down
//   en      : count enable; when low the count passes through unchanged
//   nxt     : next count value
//   wrapped : high when this step crosses the MODULUS-1 <-> 0 boundary
module count_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MODULUS = DEF_MODULUS
) (
  input  logic [WIDTH-1:0] ucount,
  input  logic             dir,
  input  logic             en,
  output logic [WIDTH-1:0] nxt,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  always_comb begin
    nxt     = ucount;
    wrapped = 1'b0;
    if (en) begin
      if (dir == DIR_UP) begin
        // >= rather than == so an out-of-range count also recovers to 0
        if (ucount >= MAXV) begin
          nxt     = '0;
          wrapped = 1'b1;
        end else begin
          nxt = ucount + WIDTH'(1);
        end
      end else begin
        if (ucount == '0) begin
          nxt     = MAXV;
          wrapped = 1'b1;
        end else begin
          nxt = ucount - WIDTH'(1);
        end
      end
    end
  end

endmodule : count_next

// File: rtl/sync_updown_counter.sv
// Modulo-MODULUS synchronous up/down counter with parallel load.
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-low reset
//   en       : count enable
//   dir      : 1 = up, 0 = down
//   load     : parallel load strobe (priority over en)
//   load_val : value to load, clamped to MODULUS-1
//   ucount   : registered count
//   dcount   : MODULUS-1-ucount
//   wrap     : one-cycle pulse after a wrap-around edge
//   at_max   : ucount == MODULUS-1
//   at_min   : ucount == 0
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] ucount,
  output logic [WIDTH-1:0] dcount,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  generate
    if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
      $error("sync_updown_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_nxt;
  logic             cnt_wrapped;
  logic [WIDTH-1:0] load_clamped;

  count_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_count_next (
    .ucount  (ucount),
    .dir     (dir),
    .en      (en),
    .nxt     (cnt_nxt),
    .wrapped (cnt_wrapped)
  );

  // Compare one bit wider so MODULUS == 2**WIDTH is representable.
  always_comb begin
    load_clamped = load_val;
    if ({1'b0, load_val} >= (WIDTH + 1)'(MODULUS))
      load_clamped = MAXV;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ucount <= '0;
      wrap   <= 1'b0;
    end else if (load) begin
      ucount <= load_clamped;
      wrap   <= 1'b0;
    end else begin
      ucount <= cnt_nxt;
      wrap   <= cnt_wrapped;
    end
  end

  assign dcount = MAXV - ucount;
  assign at_max = (ucount == MAXV);
  assign at_min = (ucount == '0);

endmodule : sync_updown_counter

// File: tb/tb_sync_updown_counter.sv
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, dir, load;
  logic [3:0] load_val;

  logic [3:0] u16, d16, u10, d10;
  logic       w16, mx16, mn16, w10, mx10, mn10;

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct {
    int u16; bit w16;
    int u10; bit w10;
  } exp_t;
  exp_t sb[$];

  int m16 = 0, m10 = 0;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .ucount(u16), .dcount(d16), .wrap(w16), .at_max(mx16), .at_min(mn16));

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .ucount(u10), .dcount(d10), .wrap(w10), .at_max(mx10), .at_min(mn10));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge of a modulo-m counter.
  task automatic model(input int m, inout int u, output bit w,
                       input logic r, input logic l, input logic [3:0] lv,
                       input logic e, input logic d);
    w = 1'b0;
    if (!r) u = 0;
    else if (l) u = (int'(lv) >= m) ? m - 1 : int'(lv);
    else if (e) begin
      if (d) begin
        w = (u == m - 1);
        u = (u + 1) % m;
      end else begin
        w = (u == 0);
        u = (u + m - 1) % m;
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [3:0] lv,
                      input logic e, input logic d);
    exp_t x;
    rst = r; load = l; load_val = lv; en = e; dir = d;
    model(16, m16, x.w16, r, l, lv, e, d);
    model(10, m10, x.w10, r, l, lv, e, d);
    x.u16 = m16; x.u10 = m10;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("u16",    32'(u16), 32'(x.u16));
    chk("d16",    32'(d16), 32'(15 - x.u16));
    chk("w16",    32'(w16), 32'(x.w16));
    chk("max16",  32'(mx16), 32'(x.u16 == 15));
    chk("min16",  32'(mn16), 32'(x.u16 == 0));
    chk("u10",    32'(u10), 32'(x.u10));
    chk("d10",    32'(d10), 32'(9 - x.u10));
    chk("w10",    32'(w10), 32'(x.w10));
    chk("max10",  32'(mx10), 32'(x.u10 == 9));
    chk("min10",  32'(mn10), 32'(x.u10 == 0));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = '0;
    #2;

    // Reset for two cycles, then up-count through a full wrap.
    step(0, 0, 4'd0, 0, 1);
    step(0, 0, 4'd0, 0, 1);
    chk("rst_u16", 32'(u16), 32'd0);
    chk("rst_d16", 32'(d16), 32'd15);
    for (int i = 0; i < 17; i++) step(1, 0, 4'd0, 1, 1);
    chk("up17_u16", 32'(u16), 32'd1);

    // Down-count from reset, MODULUS=10 wraps 0 -> 9.
    step(0, 0, 4'd0, 1, 1);
    for (int i = 0; i < 11; i++) step(1, 0, 4'd0, 1, 0);
    chk("down11_u10", 32'(u10), 32'd9);

    // Load above modulus clamps; next up edge wraps for MODULUS=10.
    step(1, 1, 4'd12, 1, 1);
    chk("clamp_u10", 32'(u10), 32'd9);
    chk("clamp_w10", 32'(w10), 32'd0);
    step(1, 0, 4'd0, 1, 1);
    chk("postclamp_w10", 32'(w10), 32'd1);

    // Load of a boundary value never pulses wrap.
    step(1, 1, 4'd15, 1, 1);
    step(1, 1, 4'd0, 1, 0);

    // Direction toggled every cycle from 5.
    step(1, 1, 4'd5, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 4'd0, 1, (i % 2 == 0));

    // Reset on the edge an up-wrap would occur.
    step(1, 1, 4'd15, 0, 1);
    step(0, 0, 4'd0, 1, 1);
    chk("rstwrap_w16", 32'(w16), 32'd0);
    chk("rstwrap_min16", 32'(mn16), 32'd1);
    step(1, 0, 4'd0, 1, 0);
    chk("first_down_u16", 32'(u16), 32'd15);

    // Hold with en=0, random dir, load_val driven X.
    step(1, 1, 4'd7, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 4'bxxxx, 0, 1'($urandom_range(0, 1)));
    chk("hold_u16", 32'(u16), 32'd7);

    // Reset overrides a simultaneous load.
    step(0, 1, 4'd3, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule : tb_sync_updown_counter

// File: doc/sync_updown_counter.md
SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning count register width in bits.
REQ-002 SHALL have parameter MODULUS, default 16, meaning count range 0..MODULUS-1, legal range 2..2^WIDTH.
REQ-003 SHALL have port clk, input, 1, meaning the single clock, all state updated on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port en, input, 1, meaning count enable.
REQ-006 SHALL have port dir, input, 1, meaning count direction, 1 = up and 0 = down.
REQ-007 SHALL have port load, input, 1, meaning synchronous parallel load strobe.
REQ-008 SHALL have port load_val, input, WIDTH, meaning value applied on load.
REQ-009 SHALL have port ucount, output, WIDTH, meaning registered count value.
REQ-010 SHALL have port dcount, output, WIDTH, meaning complement count, MODULUS-1-ucount.
REQ-011 SHALL have port wrap, output, 1, meaning one-cycle pulse following a wrap-around.
REQ-012 SHALL have port at_max, output, 1, meaning ucount == MODULUS-1.
REQ-013 SHALL have port at_min, output, 1, meaning ucount == 0.

Function
REQ-014 SHALL update ucount only on the rising clk edge, with priority rst > load > en; with none active, ucount holds.
REQ-015 SHALL, on load, set ucount to load_val, or to MODULUS-1 when load_val >= MODULUS (clamp), regardless of en and dir.
REQ-016 SHALL, with en=1 and dir=1, increment ucount, with MODULUS-1 wrapping to 0.
REQ-017 SHALL, with en=1 and dir=0, decrement ucount, with 0 wrapping to MODULUS-1.
REQ-018 SHALL register wrap: high for exactly one cycle after each edge where REQ-016 or REQ-017 wrapped, low otherwise.
REQ-019 SHALL keep wrap low after a load edge, even if the loaded value equals a boundary value.
REQ-020 SHALL apply a dir change the same edge it is sampled; there are no extra states and no pipeline delay.
REQ-021 SHALL derive dcount, at_max and at_min combinationally from ucount, with zero latency relative to ucount.
REQ-022 SHALL do all arithmetic in WIDTH bits with explicit compare-and-wrap; for MODULUS=2^WIDTH, dcount equals bitwise NOT ucount.
REQ-023 SHALL treat load_val as unused while load=0, so X on load_val SHALL NOT propagate.

Reset
REQ-024 SHALL, when rst=0 at a rising clk edge, set ucount=0 and wrap=0, giving dcount=MODULUS-1, at_min=1 and at_max=0 after that edge.
REQ-025 SHALL let reset override a simultaneous load or en, including mid-count and on the exact edge a wrap would occur (no wrap pulse).
REQ-026 SHALL leave the first count edge after reset release unaffected: the first enabled edge gives ucount=1 (up) or MODULUS-1 (down).

Structure
REQ-027 SHALL keep shared constants in package counter_pkg: default WIDTH, default MODULUS, and the direction encodings DIR_UP=1 and DIR_DOWN=0.
REQ-028 SHALL implement next-count computation in one sub-module, count_next, taking ucount, dir and en and returning next value plus wrap flag; the top holds registers, load/clamp and outputs.
REQ-029 SHALL be fully synchronous: no derived or gated clocks, no ripple clocking, and no asynchronous reset paths.
REQ-030 SHALL reject illegal MODULUS by elaboration-time check.

Verification
REQ-031 SHALL cover: rst=0 for 2 cycles, then rst=1, en=1, dir=1 for 17 cycles -> ucount 0,1..15,0, wrap high only the cycle after 15->0, dcount 15..0,15.
REQ-032 SHALL cover: MODULUS=10, en=1, dir=0 from 0 -> ucount 9,8..0,9, wrap pulses after 0->9, at_max high at 9.
REQ-033 SHALL cover: load=1, load_val=12 with MODULUS=10, en=1 -> ucount=9, wrap=0; next up-count edge -> 0 with wrap pulse.
REQ-034 SHALL cover: dir toggled every cycle with en=1 from 5 -> ucount alternates 6,5,6,5 and wrap never asserts.
REQ-035 SHALL cover: rst=0 asserted on the edge where ucount=15, en=1, dir=1 -> ucount=0, wrap stays 0, at_min=1.
REQ-036 SHALL cover: en=0 with random dir and load=0 for 20 cycles -> ucount, dcount and wrap unchanged; load_val driven X with no X on outputs.
